// File: rtl/config_word_arbiter_if.sv
// rtl/config_word_arbiter_if.sv - loader-side word sources and frame-register write bus
interface config_word_arbiter_if #(
  parameter int ROW_SEL_WIDTH = 5
);
  logic [31:0]              uart_data;
  logic                     uart_strobe;
  logic                     uart_active;
  logic [31:0]              bb_data;
  logic                     bb_strobe;
  logic                     bb_active;
  logic [1:0]               grant;
  logic                     synced;
  logic [ROW_SEL_WIDTH-1:0] RowSelect;
  logic [31:0]              FrameWord;
  logic [2:0]               FrameWordIdx;
  logic                     FrameWordStrobe;
  logic                     LongFrameStrobe;
  logic                     frame_abort;
  logic                     row_error;

  modport master (
    output uart_data, uart_strobe, uart_active, bb_data, bb_strobe, bb_active,
    input  grant, synced, RowSelect, FrameWord, FrameWordIdx,
           FrameWordStrobe, LongFrameStrobe, frame_abort, row_error
  );

  modport slave (
    input  uart_data, uart_strobe, uart_active, bb_data, bb_strobe, bb_active,
    output grant, synced, RowSelect, FrameWord, FrameWordIdx,
           FrameWordStrobe, LongFrameStrobe, frame_abort, row_error
  );
endinterface

// File: rtl/config_word_arbiter.sv
// rtl/config_word_arbiter.sv - arbitrates UART / bit-bang config loaders and parses sync/header/data frames
module config_word_arbiter #(
  parameter logic [31:0] SYNC_WORD     = 32'hFAB0_FAB1,
  parameter int          NUM_ROWS      = 16,
  parameter int          ROW_SEL_WIDTH = 5,
  parameter int          FRAME_WORDS   = 2
) (
  input logic                  CLK,
  input logic                  reset,
  config_word_arbiter_if.slave bus
);
  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT_SYNC  = 3'd1;
  localparam logic [2:0] S_GET_HEADER = 3'd2;
  localparam logic [2:0] S_GET_DATA   = 3'd3;
  localparam logic [2:0] S_SKIP_DATA  = 3'd4;
  localparam logic [2:0] LAST_IDX     = 3'(FRAME_WORDS - 1);

  logic [2:0]               state_q, state_d;
  logic [1:0]               grant_q, grant_d;
  logic                     synced_q, synced_d;
  logic [ROW_SEL_WIDTH-1:0] row_q, row_d;
  logic [31:0]              word_q, word_d;
  logic [2:0]               idx_q, idx_d;
  logic [2:0]               cnt_q, cnt_d;
  logic                     fws_q, fws_d;
  logic                     lfs_q, lfs_d;
  logic                     abort_q, abort_d;
  logic                     row_err_q, row_err_d;

  logic                     owner_active;
  logic                     acc;
  logic [31:0]              acc_word;
  logic [ROW_SEL_WIDTH-1:0] hdr_row;

  // grant_q is 00 in IDLE, so strobes in the grant cycle never count as accepted
  assign owner_active = (grant_q[0] & bus.uart_active) | (grant_q[1] & bus.bb_active);
  assign acc          = (grant_q[0] & bus.uart_strobe) | (grant_q[1] & bus.bb_strobe);
  assign acc_word     = grant_q[1] ? bus.bb_data : bus.uart_data;
  assign hdr_row      = acc_word[24 +: ROW_SEL_WIDTH];

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    synced_d  = synced_q;
    row_d     = row_q;
    word_d    = word_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    row_err_d = row_err_q;
    fws_d     = 1'b0;
    lfs_d     = 1'b0;
    abort_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.uart_active) begin
          grant_d   = 2'b01;
          state_d   = S_WAIT_SYNC;
          row_err_d = 1'b0;
        end else if (bus.bb_active) begin
          grant_d   = 2'b10;
          state_d   = S_WAIT_SYNC;
          row_err_d = 1'b0;
        end
      end
      S_WAIT_SYNC: begin
        if (acc && acc_word == SYNC_WORD) begin
          state_d  = S_GET_HEADER;
          synced_d = 1'b1;
        end
      end
      S_GET_HEADER: begin
        if (acc) begin
          cnt_d = 3'd0;
          if (acc_word[31]) begin
            state_d  = S_WAIT_SYNC;
            synced_d = 1'b0;
          end else if (32'(hdr_row) < NUM_ROWS) begin
            row_d   = hdr_row;
            state_d = S_GET_DATA;
          end else begin
            row_err_d = 1'b1;
            state_d   = S_SKIP_DATA;
          end
        end
      end
      S_GET_DATA: begin
        if (acc) begin
          word_d = acc_word;
          idx_d  = cnt_q;
          fws_d  = 1'b1;
          if (cnt_q == LAST_IDX) begin
            lfs_d   = 1'b1;
            cnt_d   = 3'd0;
            state_d = S_GET_HEADER;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      S_SKIP_DATA: begin
        if (acc) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d   = 3'd0;
            state_d = S_GET_HEADER;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Ownership loss overrides the parse result, but only after the same-cycle word was consumed
    if (state_q != S_IDLE && !owner_active) begin
      abort_d  = (state_d == S_GET_DATA) && (cnt_d != 3'd0);
      state_d  = S_IDLE;
      grant_d  = 2'b00;
      synced_d = 1'b0;
      cnt_d    = 3'd0;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      grant_q   <= 2'b00;
      synced_q  <= 1'b0;
      row_q     <= '0;
      word_q    <= 32'd0;
      idx_q     <= 3'd0;
      cnt_q     <= 3'd0;
      fws_q     <= 1'b0;
      lfs_q     <= 1'b0;
      abort_q   <= 1'b0;
      row_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      synced_q  <= synced_d;
      row_q     <= row_d;
      word_q    <= word_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      fws_q     <= fws_d;
      lfs_q     <= lfs_d;
      abort_q   <= abort_d;
      row_err_q <= row_err_d;
    end
  end

  assign bus.grant           = grant_q;
  assign bus.synced          = synced_q;
  assign bus.RowSelect       = row_q;
  assign bus.FrameWord       = word_q;
  assign bus.FrameWordIdx    = idx_q;
  assign bus.FrameWordStrobe = fws_q;
  assign bus.LongFrameStrobe = lfs_q;
  assign bus.frame_abort     = abort_q;
  assign bus.row_error       = row_err_q;
endmodule

// File: tb/tb_config_word_arbiter.sv
// tb/tb_config_word_arbiter.sv - directed scoreboard bench for config_word_arbiter
module tb_config_word_arbiter;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  typedef struct {
    logic [4:0]  row;
    logic [31:0] word;
    logic [2:0]  idx;
    logic        long_f;
  } exp_t;

  logic CLK = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_strobe = 0;
  int   n_abort  = 0;
  exp_t sb[$];

  config_word_arbiter_if #(.ROW_SEL_WIDTH(5)) bus ();

  config_word_arbiter #(
    .SYNC_WORD(SYNC), .NUM_ROWS(16), .ROW_SEL_WIDTH(5), .FRAME_WORDS(2)
  ) dut (
    .CLK(CLK), .reset(reset), .bus(bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    bus.uart_strobe = 1'b0;
    bus.bb_strobe   = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic put_u(input logic [31:0] w);
    bus.uart_data   = w;
    bus.uart_strobe = 1'b1;
    @(posedge CLK);
    #1;
    bus.uart_strobe = 1'b0;
  endtask

  task automatic put_b(input logic [31:0] w);
    bus.bb_data   = w;
    bus.bb_strobe = 1'b1;
    @(posedge CLK);
    #1;
    bus.bb_strobe = 1'b0;
  endtask

  task automatic expect_word(input logic [4:0] row, input logic [31:0] w,
                             input logic [2:0] idx, input logic lf);
    exp_t e;
    e.row = row; e.word = w; e.idx = idx; e.long_f = lf;
    sb.push_back(e);
  endtask

  always @(negedge CLK) begin
    if (!reset) begin
      if (bus.frame_abort) n_abort++;
      if (bus.LongFrameStrobe && !bus.FrameWordStrobe)
        chk("long_without_word", 32'(bus.FrameWordStrobe), 32'd1);
      if (bus.FrameWordStrobe) begin
        n_strobe++;
        n_checks++;
        assert (sb.size() > 0) else begin
          n_fail++;
          $error("FAIL unexpected_strobe observed=%h expected=none", bus.FrameWord);
        end
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_word", bus.FrameWord, e.word);
          chk("sb_idx", 32'(bus.FrameWordIdx), 32'(e.idx));
          chk("sb_row", 32'(bus.RowSelect), 32'(e.row));
          chk("sb_long", 32'(bus.LongFrameStrobe), 32'(e.long_f));
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.uart_data = 32'd0; bus.uart_strobe = 1'b0; bus.uart_active = 1'b0;
    bus.bb_data   = 32'd0; bus.bb_strobe   = 1'b0; bus.bb_active   = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_synced", 32'(bus.synced), 32'd0);
    chk("rst_frameword", bus.FrameWord, 32'd0);
    chk("rst_strobe", 32'(bus.FrameWordStrobe), 32'd0);
    chk("rst_row_error", 32'(bus.row_error), 32'd0);
    reset = 1'b0;

    // Basic UART frame with a junk word before the sync word
    bus.uart_active = 1'b1;
    idle(1);
    chk("t1_grant", 32'(bus.grant), 32'h1);
    put_u(32'h1234_5678);
    chk("t1_not_synced", 32'(bus.synced), 32'd0);
    put_u(SYNC);
    chk("t1_synced", 32'(bus.synced), 32'd1);
    put_u(32'h0300_0000);
    expect_word(5'd3, 32'hAAAA_0001, 3'd0, 1'b0);
    put_u(32'hAAAA_0001);
    expect_word(5'd3, 32'hBBBB_0002, 3'd1, 1'b1);
    put_u(32'hBBBB_0002);
    idle(2);
    chk("t1_row_hold", 32'(bus.RowSelect), 32'd3);
    chk("t1_word_hold", bus.FrameWord, 32'hBBBB_0002);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);

    // Desync header, then data without resync must be discarded
    put_u(32'h8000_0000);
    chk("t3_desync", 32'(bus.synced), 32'd0);
    put_u(32'h0100_0000);
    put_u(32'hDEAD_0001);
    put_u(32'hDEAD_0002);
    put_u(SYNC);
    chk("t3_resync", 32'(bus.synced), 32'd1);

    // Out-of-range row is skipped and sticks row_error; next frame goes through
    put_u(32'h1400_0000);
    chk("t4_row_error", 32'(bus.row_error), 32'd1);
    put_u(32'h5555_0000);
    put_u(32'h5555_0001);
    put_u(32'h0200_0000);
    expect_word(5'd2, 32'h2222_0000, 3'd0, 1'b0);
    put_u(32'h2222_0000);
    expect_word(5'd2, 32'h2222_0001, 3'd1, 1'b1);
    put_u(32'h2222_0001);
    idle(1);
    chk("t4_row2", 32'(bus.RowSelect), 32'd2);
    chk("t4_row_error_sticky", 32'(bus.row_error), 32'd1);

    // UART drops mid-frame while bit-bang waits
    bus.bb_active = 1'b1;
    put_u(32'h0100_0000);
    expect_word(5'd1, 32'h1111_0000, 3'd0, 1'b0);
    put_u(32'h1111_0000);
    bus.uart_active = 1'b0;
    idle(1);
    chk("t5_abort", 32'(bus.frame_abort), 32'd1);
    chk("t5_grant_none", 32'(bus.grant), 32'd0);
    chk("t5_synced_low", 32'(bus.synced), 32'd0);
    idle(1);
    chk("t5_grant_bb", 32'(bus.grant), 32'h2);
    chk("t5_abort_once", 32'(bus.frame_abort), 32'd0);
    chk("t5_row_error_cleared", 32'(bus.row_error), 32'd0);

    // Simultaneous request: UART wins and bit-bang words are ignored
    bus.bb_active = 1'b0;
    idle(2);
    chk("t2_idle", 32'(bus.grant), 32'd0);
    bus.uart_active = 1'b1;
    bus.bb_active   = 1'b1;
    idle(1);
    chk("t2_grant_uart", 32'(bus.grant), 32'h1);
    put_b(SYNC);
    chk("t2_bb_ignored", 32'(bus.synced), 32'd0);

    // Sync word in the grant cycle itself is ignored
    bus.uart_active = 1'b0;
    bus.bb_active   = 1'b0;
    idle(2);
    bus.uart_active = 1'b1;
    put_u(SYNC);
    chk("grant_cycle_grant", 32'(bus.grant), 32'h1);
    chk("grant_cycle_ignored", 32'(bus.synced), 32'd0);
    put_u(SYNC);
    chk("grant_cycle_resync", 32'(bus.synced), 32'd1);

    // Last word arrives in the same cycle the owner drops: frame completes, no abort
    put_u(32'h0600_0000);
    expect_word(5'd6, 32'hC000_0000, 3'd0, 1'b0);
    put_u(32'hC000_0000);
    expect_word(5'd6, 32'hC000_0001, 3'd1, 1'b1);
    bus.uart_active = 1'b0;
    put_u(32'hC000_0001);
    chk("lastdrop_no_abort", 32'(bus.frame_abort), 32'd0);
    chk("lastdrop_grant", 32'(bus.grant), 32'd0);

    // Reset in the middle of a frame
    bus.uart_active = 1'b1;
    idle(1);
    put_u(SYNC);
    put_u(32'h0500_0000);
    expect_word(5'd5, 32'hD000_0000, 3'd0, 1'b0);
    put_u(32'hD000_0000);
    idle(1);
    reset = 1'b1;
    #1;
    chk("midrst_grant", 32'(bus.grant), 32'd0);
    chk("midrst_synced", 32'(bus.synced), 32'd0);
    chk("midrst_row", 32'(bus.RowSelect), 32'd0);
    chk("midrst_word", bus.FrameWord, 32'd0);
    chk("midrst_idx", 32'(bus.FrameWordIdx), 32'd0);
    idle(1);
    reset = 1'b0;
    idle(1);
    chk("postrst_grant", 32'(bus.grant), 32'h1);
    put_u(32'h0500_0000);
    put_u(32'hE000_0000);
    put_u(32'hE000_0001);
    chk("postrst_needs_sync", 32'(bus.synced), 32'd0);
    put_u(SYNC);
    chk("postrst_synced", 32'(bus.synced), 32'd1);
    put_u(32'h0700_0000);
    expect_word(5'd7, 32'hF000_0000, 3'd0, 1'b0);
    put_u(32'hF000_0000);
    expect_word(5'd7, 32'hF000_0001, 3'd1, 1'b1);
    put_u(32'hF000_0001);
    idle(3);

    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    chk("final_strobes", 32'(n_strobe), 32'd10);
    chk("final_aborts", 32'(n_abort), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
